// File: rtl/max_pool_2x2.sv
// Streaming 2x2 / stride-2 max pool over one raster-order channel plane.
// Ports: clk, rst_n (sync, active-high), in_valid/Activation in; out_valid/pool_out/frame_done out.
module max_pool_2x2 #(
  parameter int IFM_BIT = 8,
  parameter int WIDTH   = 224,
  parameter int HEIGHT  = 224
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [IFM_BIT-1:0] Activation,
  output logic               out_valid,
  output logic [IFM_BIT-1:0] pool_out,
  output logic               frame_done
);

  localparam int HW = WIDTH / 2;
  localparam int IW = (HW > 1) ? $clog2(HW) : 1;
  localparam int CW = IW + 1;
  localparam int RW = $clog2(HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

  typedef enum logic {
    ROW_EVEN = 1'b0,
    ROW_ODD  = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  logic               px_v;
  logic [IFM_BIT-1:0] px;
  logic [CW-1:0]      col;
  logic [RW-1:0]      row;
  logic [IFM_BIT-1:0] hold;
  logic [IFM_BIT-1:0] line_buf [HW];
  logic [IW-1:0]      idx;
  logic               col_odd;
  logic               col_end;
  logic               row_end;
  logic [IFM_BIT-1:0] lb_rd;
  logic [IFM_BIT-1:0] pair_max;
  logic [IFM_BIT-1:0] quad_max;
  logic               ov_d;
  logic               fd_d;
  logic [IFM_BIT-1:0] po_d;

  assign idx     = col[IW:1];
  assign col_odd = col[0];
  assign col_end = (col == COL_LAST);
  assign row_end = (row == ROW_LAST);

  // Input capture stage; a pixel still in flight when
  // reset arrives is discarded along with the plane.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      px_v <= 1'b0;
    end else begin
      px_v <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid) begin
      px <= Activation;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      col <= '0;
      row <= '0;
    end else if (px_v) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state <= ROW_EVEN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (px_v && col_end) begin
      unique case (state)
        ROW_EVEN: state_nxt = ROW_ODD;
        ROW_ODD:  state_nxt = ROW_EVEN;
      endcase
    end
  end

  assign lb_rd    = line_buf[idx];
  assign pair_max = (hold > px) ? hold : px;
  assign quad_max = (lb_rd > pair_max) ? lb_rd : pair_max;

  // hold and line_buf need no reset: each is
  // written earlier in the window than it is read.
  always_ff @(posedge clk) begin
    if (!rst_n && px_v && !col_odd) begin
      hold <= px;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n && px_v && col_odd && state == ROW_EVEN) begin
      line_buf[idx] <= pair_max;
    end
  end

  always_comb begin
    ov_d = px_v && col_odd && (state == ROW_ODD);
    po_d = ov_d ? quad_max : '0;
    fd_d = ov_d && col_end && row_end;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      out_valid  <= 1'b0;
      pool_out   <= '0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= ov_d;
      pool_out   <= po_d;
      frame_done <= fd_d;
    end
  end

endmodule

// File: tb/tb_max_pool_2x2.sv
// Scoreboard bench for max_pool_2x2: a 4x4 instance for
// directed planes and a default 224x224 instance for a ramp.
module tb_max_pool_2x2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       v4;
  logic [7:0] a4;
  logic       ov4;
  logic [7:0] po4;
  logic       fd4;
  logic       v224;
  logic [7:0] a224;
  logic       ov224;
  logic [7:0] po224;
  logic       fd224;

  always #5 clk = ~clk;

  max_pool_2x2 #(
    .IFM_BIT(8),
    .WIDTH  (4),
    .HEIGHT (4)
  ) u4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (v4),
    .Activation(a4),
    .out_valid (ov4),
    .pool_out  (po4),
    .frame_done(fd4)
  );

  max_pool_2x2 u224 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (v224),
    .Activation(a224),
    .out_valid (ov224),
    .pool_out  (po224),
    .frame_done(fd224)
  );

  typedef struct {
    logic [7:0] v;
    logic       d;
    int         c;
  } exp_t;

  exp_t q4[$];
  exp_t q224[$];
  exp_t e4;
  exp_t e224;

  int cyc = 0;
  int pass_n = 0;
  int tot_n = 0;
  int fd4_n = 0;
  int fd224_n = 0;
  bit mon_on = 1'b0;

  logic [7:0] P  [16];
  logic [7:0] Z  [16];
  logic [7:0] E  [4];
  logic [7:0] EZ [4];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int got, input int exp);
    tot_n++;
    if (got == exp) pass_n++;
    else $display("FAIL %s: got %0d expected %0d at cycle %0d",
                  nm, got, exp, cyc);
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      if (ov4) begin
        if (q4.size() == 0) begin
          chk("p4_extra_out", ov4, 0);
        end else begin
          e4 = q4.pop_front();
          chk("p4_val", po4, e4.v);
          chk("p4_done", fd4, e4.d);
          chk("p4_cycle", cyc, e4.c);
        end
      end else begin
        chk("p4_idle_data", po4, 0);
        chk("p4_idle_done", fd4, 0);
        if (q4.size() > 0 && q4[0].c <= cyc) begin
          e4 = q4.pop_front();
          chk("p4_missing_out", ov4, 1);
        end
      end
      if (fd4) fd4_n++;

      if (ov224) begin
        if (q224.size() == 0) begin
          chk("p224_extra_out", ov224, 0);
        end else begin
          e224 = q224.pop_front();
          chk("p224_val", po224, e224.v);
          chk("p224_done", fd224, e224.d);
          chk("p224_cycle", cyc, e224.c);
        end
      end else begin
        chk("p224_idle_data", po224, 0);
        chk("p224_idle_done", fd224, 0);
        if (q224.size() > 0 && q224[0].c <= cyc) begin
          e224 = q224.pop_front();
          chk("p224_missing_out", ov224, 1);
        end
      end
      if (fd224) fd224_n++;
    end
  end

  task automatic drv4(input logic v, input logic [7:0] a);
    @(negedge clk);
    rst_n = 1'b0;
    v4    = v;
    a4    = a;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drv4(1'b0, 8'($urandom));
  endtask

  // Pixel sampled at edge N reaches pool_out after edge N+1;
  // driven at the negedge where cyc == N-1, so due at cyc+2.
  task automatic send4(input logic [7:0] px [16],
                       input logic [7:0] ex [4],
                       input bit bub, input int n, input bit exp_on);
    int k;
    exp_t t;
    k = 0;
    for (int i = 0; i < n; i++) begin
      if (bub) drv4(1'b0, 8'($urandom));
      drv4(1'b1, px[i]);
      if (exp_on && (i == 5 || i == 7 || i == 13 || i == 15)) begin
        t.v = ex[k];
        t.d = (i == 15);
        t.c = cyc + 2;
        q4.push_back(t);
        k++;
      end
    end
  endtask

  initial begin
    exp_t t;
    P  = '{8'd1, 8'd5, 8'd2, 8'd0,
           8'd3, 8'd4, 8'd9, 8'd8,
           8'd7, 8'd7, 8'd7, 8'd7,
           8'd255, 8'd0, 8'd6, 8'd10};
    E  = '{8'd5, 8'd9, 8'd255, 8'd10};
    for (int i = 0; i < 16; i++) Z[i] = 8'd0;
    for (int i = 0; i < 4; i++) EZ[i] = 8'd0;

    rst_n  = 1'b1;
    v4     = 1'b1;
    a4     = 8'($urandom);
    v224   = 1'b1;
    a224   = 8'($urandom);
    mon_on = 1'b1;
    repeat (2) begin
      @(negedge clk);
      a4   = 8'($urandom);
      a224 = 8'($urandom);
    end
    @(negedge clk);
    rst_n = 1'b0;
    v4    = 1'b0;
    v224  = 1'b0;
    idle(3);

    send4(P, E, 1'b0, 16, 1'b1);
    idle(3);

    send4(P, E, 1'b1, 16, 1'b1);
    idle(3);

    send4(P, E, 1'b0, 6, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    v4    = 1'b1;
    a4    = 8'hAA;
    send4(P, E, 1'b0, 16, 1'b1);
    idle(3);

    send4(P, E, 1'b0, 16, 1'b1);
    send4(Z, EZ, 1'b0, 16, 1'b1);
    idle(4);

    for (int r = 0; r < 224; r++) begin
      for (int c = 0; c < 224; c++) begin
        @(negedge clk);
        v224 = 1'b1;
        a224 = 8'(c);
        if (r[0] && c[0]) begin
          t.v = 8'(c);
          t.d = (r == 223 && c == 223);
          t.c = cyc + 2;
          q224.push_back(t);
        end
      end
    end
    @(negedge clk);
    v224 = 1'b0;
    repeat (4) @(negedge clk);

    chk("q4_drained", q4.size(), 0);
    chk("q224_drained", q224.size(), 0);
    chk("fd4_pulses", fd4_n, 5);
    chk("fd224_pulses", fd224_n, 1);
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end

endmodule

// File: doc/max_pool_2x2.md
# max_pool_2x2

Streaming 2x2 max-pooling stage with stride 2. It sits directly downstream of the activation (quantize + ReLU) stage in the VGG-16 datapath and consumes that stage's 8-bit activation stream. It emits one pooled activation per 2x2 window to the input-feature-map store of the next convolution layer. It processes one channel plane at a time in raster order and holds a single half-width line buffer.

## Interface

Parameters:
- IFM_BIT, 8, activation width in bits; input and output share this width.
- WIDTH, 224, feature-map width in pixels; must be even and ≥ 2.
- HEIGHT, 224, feature-map height in pixels; must be even and ≥ 2.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst_n  input  1  reset, synchronous and active-high: sampled on the rising edge of clk, asserted when 1.
- in_valid  input  1  Activation carries a valid pixel this cycle.
- Activation  input  IFM_BIT  activation pixel, unsigned (post-ReLU), raster order.
- out_valid  output  1  pool_out is valid this cycle.
- pool_out  output  IFM_BIT  pooled activation, unsigned.
- frame_done  output  1  one-cycle pulse coincident with the last pooled output of a plane.

## Operation

- Counters:
  - col counts 0..WIDTH-1 and row counts 0..HEIGHT-1.
  - Both advance only on accepted pixels (in_valid=1).
  - col wraps to 0 after WIDTH-1 and row then increments.
  - row wraps to 0 after HEIGHT-1, which starts the next plane with no gap.
- FSM has two states: ROW_EVEN (reset state) and ROW_ODD.
  - Transition happens on the accepted pixel with col=WIDTH-1.
  - ROW_EVEN→ROW_ODD always; ROW_ODD→ROW_EVEN always, including at the end of a plane.
- Pixel hold register: on each accepted even-col pixel, latch Activation into hold.
- ROW_EVEN, odd col:
  - line_buf[col>>1] ← max(hold, Activation).
  - No output.
- ROW_ODD, odd col:
  - Result = max(line_buf[col>>1], hold, Activation).
  - Result is registered to pool_out with out_valid=1.
- Line buffer:
  - WIDTH/2 entries × IFM_BIT.
  - Written only in ROW_EVEN and read only in ROW_ODD at the same index.
  - No read/write collision is possible.
- All comparisons are unsigned at IFM_BIT width. No arithmetic is performed, so there is no overflow.
- in_valid=0 cycles (bubbles) are allowed anywhere. Counters, FSM, hold and line_buf are frozen during bubbles.
- Any value on Activation while in_valid=0 is ignored.
- frame_done=1 together with the output produced by pixel (row=HEIGHT-1, col=WIDTH-1).
- Reset:
  - Clears col, row, FSM (→ROW_EVEN), out_valid, pool_out and frame_done.
  - hold and line_buf are not cleared; they are always written before they are read.
  - Reset mid-plane discards the partial plane. The next accepted pixel is treated as (row 0, col 0).
  - Reset has priority over in_valid in the same cycle; that pixel is dropped.

## Timing

- Reset values: out_valid=0, pool_out=0, frame_done=0.
- Latency: 1 cycle. An input accepted at edge N (ROW_ODD, odd col) gives out_valid=1 and pool_out valid after edge N+1, for exactly one cycle.
- When out_valid=0, pool_out is driven to 0.
- Throughput: 1 pixel/cycle in; at most 1 output per 2 cycles, and outputs appear only during odd rows.
- Per plane: exactly (WIDTH/2)*(HEIGHT/2) outputs and one frame_done pulse.
- There is no backpressure. The downstream stage must accept out_valid every cycle it is asserted.

## Test plan

- Basic 4x4 (WIDTH=HEIGHT=4), contiguous input:
  - Rows: 1 5 2 0 / 3 4 9 8 / 7 7 7 7 / 255 0 6 10.
  - Required outputs: 5, 9, 255, 10, one cycle after input indices 5, 7, 13, 15.
  - frame_done only with 10.
- Bubbles: same 4x4 data with in_valid low on every other cycle.
  - Required: identical values 5, 9, 255, 10.
  - Each output appears exactly one cycle after its triggering pixel.
  - out_valid=0 and pool_out=0 elsewhere.
- Reset mid-plane:
  - Send the first 6 pixels of the 4x4 plane, assert rst_n=1 for one cycle while in_valid=1, then send the full plane.
  - Required: exactly 4 outputs 5, 9, 255, 10 and one frame_done.
  - No output from the aborted plane.
- Back-to-back planes:
  - Send the 4x4 plane, then immediately an all-zero 4x4 plane.
  - Required: 5, 9, 255, 10, then 0, 0, 0, 0.
  - Two frame_done pulses; no stale line_buf data leaks into the second plane.
- Default parameters (224x224), ramp data:
  - Pixel value = col mod 256, row-independent.
  - Required: 12544 outputs with output k in a row equal to 2k+1 for k<112.
  - One frame_done pulse, on output 12544.
- Reset state:
  - Hold rst_n=1 for 3 cycles with in_valid=1 and random data.
  - Required: out_valid, pool_out and frame_done stay 0 during reset and on the first cycle after it.
